// File: rtl/mar_agu.sv
// Memory address register with an address-generation unit: bus load, +1/+stride
// increment, and a KSIZE x KSIZE kernel-window scan for the convolution datapath.
module mar_agu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int IMG_W  = 64,
    parameter int KSIZE  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              inc_en,
    input  logic              inc_mode,
    input  logic              scan_start,
    input  logic              scan_adv,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] data_addr,
    output logic              scan_busy,
    output logic              scan_done,
    output logic              wrap
);
    localparam int CW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam logic [CW-1:0]     KLAST  = CW'(KSIZE - 1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic [ADDR_W-1:0] row_off, row_off_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [CW-1:0]     row, row_nxt, col, col_nxt;
    logic [DATA_W-1:0] out_nxt;
    logic              busy_nxt, done_nxt, wrap_nxt;

    logic [ADDR_W:0]   inc_sum;
    logic [ADDR_W-1:0] col_addr, row_off_step, row_addr;

    // Running row offset replaces row*IMG_W; each row step adds one stride.
    always_comb begin
        inc_sum      = {1'b0, base} + {1'b0, (inc_mode ? STRIDE : ADDR_W'(1))};
        col_addr     = data_addr + ADDR_W'(1);
        row_off_step = row_off + STRIDE;
        row_addr     = base + row_off_step;

        state_nxt   = state;
        base_nxt    = base;
        row_off_nxt = row_off;
        addr_nxt    = data_addr;
        row_nxt     = row;
        col_nxt     = col;
        out_nxt     = data_out;
        busy_nxt    = scan_busy;
        done_nxt    = 1'b0;
        wrap_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (scan_start) begin
                    row_nxt     = '0;
                    col_nxt     = '0;
                    row_off_nxt = '0;
                    addr_nxt    = base;
                    busy_nxt    = 1'b1;
                    state_nxt   = SCAN;
                end else if (w_en) begin
                    out_nxt  = data_in;
                    base_nxt = data_in[ADDR_W-1:0];
                    addr_nxt = data_in[ADDR_W-1:0];
                end else if (inc_en) begin
                    base_nxt = inc_sum[ADDR_W-1:0];
                    addr_nxt = inc_sum[ADDR_W-1:0];
                    wrap_nxt = inc_sum[ADDR_W];
                end
            end
            SCAN: begin
                if (scan_adv) begin
                    if (col != KLAST) begin
                        col_nxt  = col + CW'(1);
                        addr_nxt = col_addr;
                        wrap_nxt = (col_addr < data_addr);
                    end else if (row != KLAST) begin
                        col_nxt     = '0;
                        row_nxt     = row + CW'(1);
                        row_off_nxt = row_off_step;
                        addr_nxt    = row_addr;
                        wrap_nxt    = (row_addr < data_addr);
                    end else begin
                        // Returning to base at the end is not a window step, so no wrap.
                        addr_nxt  = base;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            row_off   <= '0;
            row       <= '0;
            col       <= '0;
            data_out  <= '0;
            data_addr <= '0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            base      <= base_nxt;
            row_off   <= row_off_nxt;
            row       <= row_nxt;
            col       <= col_nxt;
            data_out  <= out_nxt;
            data_addr <= addr_nxt;
            scan_busy <= busy_nxt;
            scan_done <= done_nxt;
            wrap      <= wrap_nxt;
        end
    end
endmodule

// File: tb/tb_mar_agu.sv
// Bench for mar_agu: directed test-plan steps then random traffic, every cycle
// compared against a window-index reference model.
module tb_mar_agu;
    localparam int DW = 32, AW = 12, IW = 64, K = 3;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n, w_en, inc_en, inc_mode, scan_start, scan_adv;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic [AW-1:0] data_addr;
    logic          scan_busy, scan_done, wrap;

    int vectors = 0;
    int errs    = 0;

    // reference model state
    int m_out, m_base, m_addr, m_idx;
    bit m_scan, m_done_cyc, m_done, m_wrap;

    mar_agu #(.DATA_W(DW), .ADDR_W(AW), .IMG_W(IW), .KSIZE(K)) dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in),
        .inc_en(inc_en), .inc_mode(inc_mode), .scan_start(scan_start),
        .scan_adv(scan_adv), .data_out(data_out), .data_addr(data_addr),
        .scan_busy(scan_busy), .scan_done(scan_done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int win_addr(input int b, input int idx);
        return (b + (idx / K) * IW + (idx % K)) % AMOD;
    endfunction

    task automatic model_step();
        int nxt;
        m_wrap = 0;
        m_done = 0;
        if (!rst_n) begin
            m_out = 0; m_base = 0; m_addr = 0; m_idx = 0;
            m_scan = 0; m_done_cyc = 0;
        end else if (m_done_cyc) begin
            m_done_cyc = 0;
        end else if (m_scan) begin
            if (scan_adv) begin
                if (m_idx == K * K - 1) begin
                    m_scan = 0; m_done = 1; m_done_cyc = 1; m_addr = m_base;
                end else begin
                    m_idx++;
                    nxt    = win_addr(m_base, m_idx);
                    m_wrap = (nxt < m_addr);
                    m_addr = nxt;
                end
            end
        end else if (scan_start) begin
            m_scan = 1; m_idx = 0; m_addr = m_base;
        end else if (w_en) begin
            m_out  = data_in;
            m_base = data_in % AMOD;
            m_addr = m_base;
        end else if (inc_en) begin
            nxt    = m_base + (inc_mode ? IW : 1);
            m_wrap = (nxt >= AMOD);
            m_base = nxt % AMOD;
            m_addr = m_base;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("data_out", data_out, m_out);
        chk("data_addr", 32'(data_addr), m_addr);
        chk("scan_busy", 32'(scan_busy), 32'(m_scan));
        chk("scan_done", 32'(scan_done), 32'(m_done));
        chk("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    task automatic idle();
        w_en = 0; inc_en = 0; inc_mode = 0; scan_start = 0; scan_adv = 0;
    endtask

    task automatic load(input logic [31:0] v);
        idle(); w_en = 1; data_in = v; tick(); w_en = 0;
    endtask

    initial begin
        logic [AW-1:0] seq [9];
        logic [AW-1:0] wseq [9];
        seq  = '{12'h100, 12'h101, 12'h102, 12'h140, 12'h141, 12'h142, 12'h180, 12'h181, 12'h182};
        wseq = '{12'hFBF, 12'hFC0, 12'hFC1, 12'hFFF, 12'h000, 12'h001, 12'h03F, 12'h040, 12'h041};
        idle(); data_in = '0; rst_n = 0;
        tick(); tick();
        chk("rst_addr", 32'(data_addr), 32'h0);
        rst_n = 1;

        // load and increments
        load(32'hA5A5A5A5);
        chk("load_out", data_out, 32'hA5A5A5A5);
        chk("load_addr", 32'(data_addr), 32'h5A5);
        load(32'h010);
        inc_en = 1; inc_mode = 0; tick();
        chk("inc1", 32'(data_addr), 32'h011);
        inc_mode = 1; tick();
        chk("inc_stride", 32'(data_addr), 32'h051);
        load(32'hFFF);
        inc_en = 1; inc_mode = 0; tick();
        chk("inc_wrap_addr", 32'(data_addr), 32'h000);
        chk("inc_wrap_flag", 32'(wrap), 32'h1);
        idle(); tick();
        chk("wrap_clear", 32'(wrap), 32'h0);

        // continuous scan
        load(32'h100);
        scan_start = 1; tick(); scan_start = 0;
        chk("scan_seq0", 32'(data_addr), 32'(seq[0]));
        scan_adv = 1;
        for (int i = 1; i < 9; i++) begin
            tick();
            chk("scan_seq", 32'(data_addr), 32'(seq[i]));
        end
        tick();
        chk("scan_done", 32'(scan_done), 32'h1);
        chk("scan_ret_base", 32'(data_addr), 32'h100);
        scan_adv = 0; tick();
        chk("done_pulse", 32'(scan_done), 32'h0);

        // stalled scan with ignored commands
        scan_start = 1; tick(); scan_start = 0;
        scan_adv = 1; tick(); scan_adv = 0;
        w_en = 1; data_in = 32'h12345777; inc_en = 1; inc_mode = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_addr", 32'(data_addr), 32'h101);
            chk("stall_out", data_out, 32'h100);
        end
        idle(); scan_adv = 1;
        for (int i = 2; i < 9; i++) begin
            tick();
            chk("resume_seq", 32'(data_addr), 32'(seq[i]));
        end
        tick(); scan_adv = 0; tick();

        // scan that wraps modulo 2^ADDR_W
        load(32'hFBF);
        scan_start = 1; tick(); scan_start = 0; scan_adv = 1;
        for (int i = 1; i < 9; i++) begin
            tick();
            chk("wscan_seq", 32'(data_addr), 32'(wseq[i]));
            if (i == 4) chk("wscan_wrap", 32'(wrap), 32'h1);
        end
        tick(); scan_adv = 0; tick();

        // reset mid-scan
        load(32'h100);
        scan_start = 1; tick(); scan_start = 0; scan_adv = 1;
        tick(); tick();
        scan_adv = 0; rst_n = 0; tick();
        chk("mid_rst_addr", 32'(data_addr), 32'h0);
        chk("mid_rst_busy", 32'(scan_busy), 32'h0);
        rst_n = 1; tick();
        load(32'h200);
        scan_start = 1; tick(); scan_start = 0;
        chk("fresh_scan", 32'(data_addr), 32'h200);
        scan_adv = 1;
        for (int i = 0; i < 10; i++) tick();
        idle(); tick();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst_n      = ($urandom_range(0, 149) != 0);
            w_en       = ($urandom_range(0, 3) == 0);
            data_in    = $urandom;
            if ($urandom_range(0, 1) == 1) data_in[11:4] = 8'hFF;
            inc_en     = ($urandom_range(0, 2) == 0);
            inc_mode   = 1'($urandom_range(0, 1));
            scan_start = ($urandom_range(0, 7) == 0);
            scan_adv   = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
